// File: rtl/rrc_interp_filter_if.sv
// Symbol-in / sample-out bus of the I/Q RRC interpolator, plus the coefficient
// write port and status. master = upstream/controller side, slave = filter.
interface rrc_interp_filter_if #(
  parameter int DW   = 4,
  parameter int CW   = 8,
  parameter int TAPS = 11,
  parameter int SPS  = 4,
  parameter int OW   = 16
);
  localparam int CAW = $clog2(TAPS);
  localparam int PW  = $clog2(SPS);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_i;
  logic signed [DW-1:0]  in_q;
  logic                  coef_we;
  logic [CAW-1:0]        coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [OW-1:0]  out_i;
  logic signed [OW-1:0]  out_q;
  logic [PW-1:0]         out_phase;
  logic                  busy;
  logic                  sat;

  modport master (
    output in_valid, in_i, in_q, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_i, out_q, out_phase, busy, sat
  );

  modport slave (
    input  in_valid, in_i, in_q, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_i, out_q, out_phase, busy, sat
  );
endinterface

// File: rtl/rrc_interp_filter.sv
// I/Q root-raised-cosine interpolating FIR (polyphase, one MAC per channel).
// Each accepted symbol produces SPS output samples; phase p is
// sum_j h[p + j*SPS] * s[j] over the NSYM-deep symbol delay line.
// Optional feature: define RRC_INTERP_SAT_EN for saturating output narrowing
// with a sticky sat flag; otherwise the output wraps and sat is 0.
module rrc_interp_filter #(
  parameter int DW     = 4,
  parameter int CW     = 8,
  parameter int TAPS   = 11,
  parameter int SPS    = 4,
  parameter int OW     = 16,
  parameter int OSHIFT = 0
) (
  input  logic clk,
  input  logic rst_n,
  rrc_interp_filter_if.slave bus
);
  localparam int NSYM = (TAPS + SPS - 1) / SPS;
  localparam int NPAD = NSYM * SPS;
  localparam int AW   = DW + CW + $clog2(NSYM) + 1;
  localparam int PW   = $clog2(SPS);
  localparam int JW   = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int IW   = $clog2(NPAD);
  localparam int WW   = ((AW > OW) ? AW : OW) + 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                state_q, state_d;
  logic signed [DW-1:0]  sym_i [NSYM];
  logic signed [DW-1:0]  sym_q [NSYM];
  logic signed [CW-1:0]  coef_q [TAPS];
  logic signed [CW-1:0]  coef_ext [NPAD];
  logic [PW-1:0]         phase_q;
  logic [JW-1:0]         j_q;
  logic signed [AW-1:0]  acc_i_q, acc_q_q, acc_i_nxt, acc_q_nxt;
  logic signed [DW+CW-1:0] prod_i, prod_q;
  logic [IW-1:0]         tap_idx;
  logic signed [OW-1:0]  out_i_q, out_q_q;
  logic [PW-1:0]         out_phase_q;
  logic                  mac_last, phase_last;

`ifdef RRC_INTERP_SAT_EN
  localparam logic signed [WW-1:0] OMAX = WW'((2 ** (OW - 1)) - 1);
  localparam logic signed [WW-1:0] OMIN = ~OMAX;
  logic sat_q;

  function automatic logic signed [OW-1:0] narrow(input logic signed [AW-1:0] a);
    logic signed [WW-1:0] w;
    w = WW'(a >>> OSHIFT);
    if (w > OMAX)      return OW'(OMAX);
    else if (w < OMIN) return OW'(OMIN);
    else               return OW'(w);
  endfunction

  function automatic logic clipped(input logic signed [AW-1:0] a);
    logic signed [WW-1:0] w;
    w = WW'(a >>> OSHIFT);
    return (w > OMAX) || (w < OMIN);
  endfunction
`else
  function automatic logic signed [OW-1:0] narrow(input logic signed [AW-1:0] a);
    return OW'(WW'(a >>> OSHIFT));
  endfunction
`endif

  // Taps beyond TAPS-1 read as zero so the last polyphase branch stays uniform.
  for (genvar k = 0; k < NPAD; k++) begin : g_pad
    if (k < TAPS) begin : g_tap
      assign coef_ext[k] = coef_q[k];
    end else begin : g_zero
      assign coef_ext[k] = '0;
    end
  end

  assign mac_last   = (j_q == JW'(NSYM - 1));
  assign phase_last = (phase_q == PW'(SPS - 1));

  // One multiply-accumulate term per channel for the current (phase, j).
  always_comb begin
    tap_idx   = IW'(phase_q) + IW'(j_q) * IW'(SPS);
    prod_i    = coef_ext[tap_idx] * sym_i[j_q];
    prod_q    = coef_ext[tap_idx] * sym_q[j_q];
    acc_i_nxt = acc_i_q + AW'(prod_i);
    acc_q_nxt = acc_q_q + AW'(prod_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = MAC;
      MAC:  if (mac_last)     state_d = OUT;
      OUT:  if (bus.out_ready) state_d = phase_last ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: coefficient file, delay line, phase/tap counters, accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the coefficient file and delay line are reset because a freshly
      // reset filter must produce zeros until coefficients are reloaded.
      for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
      for (int k = 0; k < NSYM; k++) begin
        sym_i[k] <= '0;
        sym_q[k] <= '0;
      end
      phase_q     <= '0;
      j_q         <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_phase_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.coef_we && (32'(bus.coef_addr) < TAPS))
            coef_q[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid) begin
            sym_i[0] <= bus.in_i;
            sym_q[0] <= bus.in_q;
            for (int k = 1; k < NSYM; k++) begin
              sym_i[k] <= sym_i[k-1];
              sym_q[k] <= sym_q[k-1];
            end
            phase_q <= '0;
            j_q     <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
          end
        end
        MAC: begin
          j_q     <= j_q + JW'(1);
          acc_i_q <= acc_i_nxt;
          acc_q_q <= acc_q_nxt;
          if (mac_last) begin
            out_i_q     <= narrow(acc_i_nxt);
            out_q_q     <= narrow(acc_q_nxt);
            out_phase_q <= phase_q;
          end
        end
        OUT: begin
          if (bus.out_ready && !phase_last) begin
            phase_q <= phase_q + PW'(1);
            j_q     <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RRC_INTERP_SAT_EN
  // Sticky saturation flag, set whenever a produced sample was clipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else if (state_q == MAC && mac_last &&
             (clipped(acc_i_nxt) || clipped(acc_q_nxt))) sat_q <= 1'b1;
  end
`endif

  // Output decode from state and the registered sample.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == OUT);
    bus.out_i     = out_i_q;
    bus.out_q     = out_q_q;
    bus.out_phase = out_phase_q;
`ifdef RRC_INTERP_SAT_EN
    bus.sat       = sat_q;
`else
    bus.sat       = 1'b0;
`endif
  end
endmodule

// File: tb/tb_rrc_interp_filter.sv
// Self-checking bench for rrc_interp_filter. Two instances share all inputs:
// A (OW=16) and B (OW=8, exercises narrowing). The reference model computes
// each sample as the zero-stuffed-upsampled symbol stream convolved with h.
module tb_rrc_interp_filter;
  localparam int DW = 4, CW = 8, TAPS = 11, SPS = 4, OSHIFT = 0;
  localparam int NSYM = (TAPS + SPS - 1) / SPS;

`ifdef RRC_INTERP_SAT_EN
  localparam int SAT_LIT = -128, SAT_FLAG = 1;
`else
  localparam int SAT_LIT = 24, SAT_FLAG = 0;
`endif

  logic clk, rst_n;
  int n_cmp = 0, n_fail = 0;

  rrc_interp_filter_if #(.DW(DW), .CW(CW), .TAPS(TAPS), .SPS(SPS), .OW(16)) aif ();
  rrc_interp_filter_if #(.DW(DW), .CW(CW), .TAPS(TAPS), .SPS(SPS), .OW(8))  bif ();

  rrc_interp_filter #(.DW(DW), .CW(CW), .TAPS(TAPS), .SPS(SPS), .OW(16), .OSHIFT(OSHIFT))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(aif));
  rrc_interp_filter #(.DW(DW), .CW(CW), .TAPS(TAPS), .SPS(SPS), .OW(8), .OSHIFT(OSHIFT))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bif));

  assign bif.in_valid  = aif.in_valid;
  assign bif.in_i      = aif.in_i;
  assign bif.in_q      = aif.in_q;
  assign bif.coef_we   = aif.coef_we;
  assign bif.coef_addr = aif.coef_addr;
  assign bif.coef_data = aif.coef_data;
  assign bif.out_ready = aif.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     h [TAPS];
  int     hist_i [$], hist_q [$];
  bit     m_busy, exp_valid, sat_a, sat_b;
  int     m_phase, m_wait;
  longint ea_i, ea_q, eb_i, eb_q;

  function automatic longint conv(input bit use_q);
    longint y = 0;
    int n = hist_i.size() - 1;
    int m = n * SPS + m_phase;
    for (int k = 0; k < TAPS; k++) begin
      int t = m - k;
      if (t >= 0 && (t % SPS) == 0)
        y += longint'(h[k]) * (use_q ? hist_q[t / SPS] : hist_i[t / SPS]);
    end
    return y >>> OSHIFT;
  endfunction

  function automatic longint narrow(input longint v, input int ow, output bit clip);
    longint mx = (longint'(1) <<< (ow - 1)) - 1;
    longint mn = -mx - 1;
    longint r;
`ifdef RRC_INTERP_SAT_EN
    clip = (v > mx) || (v < mn);
    r = (v > mx) ? mx : (v < mn) ? mn : v;
`else
    clip = 1'b0;
    r = v & ((longint'(1) <<< ow) - 1);
    if (r > mx) r -= (longint'(1) <<< ow);
`endif
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) h[k] = 0;
      hist_i.delete(); hist_q.delete();
      m_busy = 0; exp_valid = 0; sat_a = 0; sat_b = 0;
      m_phase = 0; m_wait = 0;
      ea_i = 0; ea_q = 0; eb_i = 0; eb_q = 0;
    end else if (!m_busy) begin
      if (aif.coef_we && aif.coef_addr < TAPS) h[aif.coef_addr] = int'(aif.coef_data);
      if (aif.in_valid) begin
        hist_i.push_back(int'(aif.in_i));
        hist_q.push_back(int'(aif.in_q));
        m_busy = 1; m_phase = 0; m_wait = NSYM;
      end
    end else if (exp_valid) begin
      if (aif.out_ready) begin
        exp_valid = 0;
        if (m_phase == SPS - 1) m_busy = 0;
        else begin m_phase++; m_wait = NSYM; end
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        longint yi, yq;
        bit c1, c2, c3, c4;
        yi = conv(0); yq = conv(1);
        ea_i = narrow(yi, 16, c1); ea_q = narrow(yq, 16, c2);
        eb_i = narrow(yi, 8, c3);  eb_q = narrow(yq, 8, c4);
        sat_a |= c1 | c2; sat_b |= c3 | c4;
        exp_valid = 1;
      end
    end
  end

  // ---------------- compare process + capture ----------------
  bit     cap_en = 0;
  longint cap_ai [$], cap_aq [$], cap_ap [$], cap_bi [$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("a_in_ready", aif.in_ready, !m_busy);
      check("a_busy", aif.busy, m_busy);
      check("a_out_valid", aif.out_valid, exp_valid);
      check("b_out_valid", bif.out_valid, exp_valid);
      check("a_sat", aif.sat, sat_a);
      check("b_sat", bif.sat, sat_b);
      if (exp_valid) begin
        check("a_out_i", aif.out_i, ea_i);
        check("a_out_q", aif.out_q, ea_q);
        check("a_out_phase", aif.out_phase, m_phase);
        check("b_out_i", bif.out_i, eb_i);
        check("b_out_q", bif.out_q, eb_q);
      end
      if (cap_en && aif.out_valid && aif.out_ready) begin
        cap_ai.push_back(aif.out_i); cap_aq.push_back(aif.out_q);
        cap_ap.push_back(aif.out_phase); cap_bi.push_back(bif.out_i);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_en = 0;

  task automatic rand_inputs();
    if (rand_en) begin
      aif.out_ready = ($urandom_range(0, 3) != 0);
      aif.coef_we   = ($urandom_range(0, 7) == 0);
      aif.coef_addr = 4'($urandom_range(0, 15));
      aif.coef_data = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    rand_inputs();
  endtask

  task automatic send(input int si, input int sq);
    bit got = 0;
    aif.in_valid = 1'b1;
    aif.in_i = 4'(si);
    aif.in_q = 4'(sq);
    for (int n = 0; n < 300 && !got; n++) begin
      @(posedge clk);
      got = aif.in_ready;
      #1;
      rand_inputs();
    end
    aif.in_valid = 1'b0;
    if (!got) check("send_accept", got, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500 && !aif.in_ready; n++) tick();
    check("idle_wait", aif.in_ready, 1);
  endtask

  task automatic write_coef(input int a, input int d);
    aif.coef_we = 1'b1;
    aif.coef_addr = 4'(a);
    aif.coef_data = 8'(d);
    tick();
    aif.coef_we = 1'b0;
  endtask

  task automatic clear_cap();
    cap_ai.delete(); cap_aq.delete(); cap_ap.delete(); cap_bi.delete();
  endtask

  // Impulse after two flushing zero symbols; optional coef write while busy.
  task automatic impulse_first(input bit poke_busy, output longint first);
    send(0, 0); send(0, 0); wait_idle();
    clear_cap(); cap_en = 1;
    send(1, -1);
    if (poke_busy) write_coef(0, 50);
    wait_idle();
    cap_en = 0;
    check("impulse_cap_count", cap_ai.size(), SPS);
    first = (cap_ai.size() > 0) ? cap_ai[0] : -9999;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int imp_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0};
    int lat, n;
    longint first, hold_i, hold_q, hold_p;

    aif.in_valid = 0; aif.in_i = '0; aif.in_q = '0;
    aif.coef_we = 0; aif.coef_addr = '0; aif.coef_data = '0;
    aif.out_ready = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", aif.in_ready, 1);
    check("rst_out_valid", aif.out_valid, 0);
    check("rst_out_i", aif.out_i, 0);
    check("rst_out_q", aif.out_q, 0);
    check("rst_out_phase", aif.out_phase, 0);
    check("rst_busy", aif.busy, 0);
    check("rst_sat", aif.sat, 0);
    @(negedge clk) rst_n = 1;

    // Impulse response with h[k] = k+1; out-of-range address ignored.
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    write_coef(13, 99);
    aif.out_ready = 1;
    clear_cap(); cap_en = 1;
    send(1, -1); send(0, 0); send(0, 0);
    wait_idle();
    cap_en = 0;
    check("imp_count", cap_ai.size(), 12);
    for (int k = 0; k < 12 && k < cap_ai.size(); k++) begin
      check("imp_out_i", cap_ai[k], imp_exp[k]);
      check("imp_out_q", cap_aq[k], -imp_exp[k]);
      check("imp_phase", cap_ap[k], k % SPS);
    end

    // Latency and symbol period with out_ready held high.
    send(3, 2);
    lat = 0; n = 1;
    while (!aif.in_ready && n < 100) begin
      if (lat == 0 && aif.out_valid) lat = n;
      tick(); n++;
    end
    check("latency_first_valid", lat, 4);
    check("in_ready_return_cycle", n, 17);

    // Backpressure at phase 1.
    aif.out_ready = 0;
    send(5, -3);
    for (int k = 0; k < 50 && !aif.out_valid; k++) tick();
    check("bp_valid_ph0", aif.out_valid, 1);
    aif.out_ready = 1; tick(); aif.out_ready = 0;
    for (int k = 0; k < 50 && !aif.out_valid; k++) tick();
    check("bp_valid_ph1", aif.out_valid, 1);
    check("bp_phase", aif.out_phase, 1);
    hold_i = ea_i; hold_q = ea_q; hold_p = 1;
    repeat (5) begin
      tick();
      check("bp_hold_i", aif.out_i, hold_i);
      check("bp_hold_q", aif.out_q, hold_q);
      check("bp_hold_phase", aif.out_phase, hold_p);
      check("bp_in_ready", aif.in_ready, 0);
    end
    aif.out_ready = 1;
    wait_idle();

    // Coefficient write while busy is ignored; the same write in IDLE applies.
    impulse_first(1, first);
    check("coef_busy_ignored", first, 1);
    write_coef(0, 50);
    impulse_first(0, first);
    check("coef_idle_applied", first, 50);

    // Randomized traffic, backpressure and coefficient writes.
    rand_en = 1;
    for (int s = 0; s < 250; s++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    rand_en = 0;
    aif.coef_we = 0;
    aif.out_ready = 1;
    wait_idle();

    // Mid-operation reset: immediate abort, coefficients cleared.
    send(1, 1);
    #2 rst_n = 0;
    #1;
    check("mreset_out_valid", aif.out_valid, 0);
    check("mreset_in_ready", aif.in_ready, 1);
    check("mreset_busy", aif.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    clear_cap(); cap_en = 1;
    send(1, -1); send(0, 0); send(0, 0);
    wait_idle();
    cap_en = 0;
    check("mreset_cap_count", cap_ai.size(), 12);
    for (int k = 0; k < cap_ai.size(); k++) check("mreset_zero_out", cap_ai[k], 0);
    check("mreset_b_sat", bif.sat, 0);

    // Saturation: all h = 127, steady -8 input, phase 0 of the third symbol.
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    send(-8, -8); send(-8, -8); wait_idle();
    clear_cap(); cap_en = 1;
    send(-8, -8); wait_idle();
    cap_en = 0;
    check("sat_cap_count", cap_bi.size(), SPS);
    if (cap_bi.size() > 0) begin
      check("sat_b_phase0", cap_bi[0], SAT_LIT);
      check("sat_a_phase0", cap_ai[0], -3048);
    end
    check("sat_b_flag", bif.sat, SAT_FLAG);
    check("sat_a_flag", aif.sat, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
